// File: rtl/inst_fetch_queue.sv
// Fetch-to-decode instruction queue: DEPTH {pc, inst} entries with show-ahead head.
// Define IFQ_BYPASS_EN to let a beat pass straight through an empty queue in zero cycles.
module inst_fetch_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [XLEN-1:0]   inst_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [XLEN-1:0]   pc_o,
    output logic [XLEN-1:0]   inst_o,
    output logic [ADDR_W:0]   level_o
);

    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] EMPTY_LVL = (ADDR_W + 1)'(0);

    logic [2*XLEN-1:0] mem_r [DEPTH];
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W:0]   count_r;
    logic              has_data_s;
    logic              bypass_s;
    logic              push_s;
    logic              pop_s;
    logic [2*XLEN-1:0] head_s;

    assign has_data_s = (count_r != EMPTY_LVL);
    assign head_s     = mem_r[rd_ptr_r];
    // Ready depends only on registered occupancy, so a full queue refuses even while popping.
    assign in_ready_o = (count_r != FULL_LVL);
    assign level_o    = count_r;

`ifdef IFQ_BYPASS_EN
    assign bypass_s = ~has_data_s & in_valid_i & out_ready_i & ~stall_i & ~flush_i;
`else
    assign bypass_s = 1'b0;
`endif

    assign push_s = in_valid_i & in_ready_o & ~flush_i & ~bypass_s;
    assign pop_s  = has_data_s & out_ready_i & ~stall_i & ~flush_i;

    // Head presentation toward decode; zeroed when nothing is available.
    always_comb begin
        out_valid_o = 1'b0;
        pc_o        = {XLEN{1'b0}};
        inst_o      = {XLEN{1'b0}};
        if (bypass_s) begin
            out_valid_o = 1'b1;
            pc_o        = pc_i;
            inst_o      = inst_i;
        end else if (has_data_s) begin
            out_valid_o = 1'b1;
            pc_o        = head_s[2*XLEN-1:XLEN];
            inst_o      = head_s[XLEN-1:0];
        end else begin
            out_valid_o = 1'b0;
        end
    end

    // Entry storage; intentionally not cleared by reset.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {pc_i, inst_i};
        end
    end

    // Pointers and occupancy; reset and flush both empty the queue.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rd_ptr_r <= {ADDR_W{1'b0}};
            wr_ptr_r <= {ADDR_W{1'b0}};
            count_r  <= EMPTY_LVL;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (ADDR_W + 1)'(1);
                2'b01:   count_r <= count_r - (ADDR_W + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule
